// File: rtl/memory_controller.sv
// Byte-wide simple dual-port framebuffer memory with a post-reset clear sweep.
// Registered read port with write-first bypass applied after the RAM output register.
`timescale 1ns/1ps

module memory_controller #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              weW,
  input  logic [ADDR_W-1:0] addrW,
  input  logic [DATA_W-1:0] dataW,
  input  logic              reR,
  input  logic [ADDR_W-1:0] addrR,
  output logic [DATA_W-1:0] dataR,
  output logic              validR,
  output logic              ready
);

  localparam int unsigned       DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t              state, stateNext;
  logic [ADDR_W:0]     clrCnt;     // extra MSB flags "every location written"
  logic                clearing;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                memWe;
  logic [ADDR_W-1:0]   memAddr;
  logic [DATA_W-1:0]   memData;

  logic                rdAcc;
  logic                bypHit;
  logic [DATA_W-1:0]   ramQ;
  logic [DATA_W-1:0]   bypData;
  logic                bypSel;
  logic                haveData;

  // State register (sweep counter advances alongside it)
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_CLEAR;
      clrCnt <= '0;
    end else begin
      state <= stateNext;
      if (clearing) clrCnt <= clrCnt + CNT_ONE;
    end
  end

  // Next-state logic
  // NOTE: default assignment first so no path through always_comb leaves stateNext unassigned (no latch).
  always_comb begin
    stateNext = state;
    case (state)
      S_CLEAR: if (!CLEAR_ON_RESET || clrCnt[ADDR_W]) stateNext = S_READY;
      S_READY: stateNext = S_READY;
      default: stateNext = S_CLEAR;
    endcase
  end

  // Output logic
  always_comb begin
    ready    = (state == S_READY);
    clearing = (state == S_CLEAR) && CLEAR_ON_RESET && !clrCnt[ADDR_W];
  end

  // Write port is borrowed by the sweep until ready; user requests are dropped until then.
  always_comb begin
    rdAcc   = ready && reR;
    memWe   = clearing || (ready && weW);
    memAddr = clearing ? clrCnt[ADDR_W-1:0] : addrW;
    memData = clearing ? '0 : dataW;
    bypHit  = rdAcc && weW && (addrW == addrR);
  end

  // NOTE: the array and its output register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (memWe) mem[memAddr] <= memData;
    if (rdAcc) ramQ <= mem[addrR];
  end

  // Read-side control; haveData masks the unreset RAM register until the first real read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validR   <= 1'b0;
      haveData <= 1'b0;
      bypSel   <= 1'b0;
      bypData  <= '0;
    end else begin
      validR <= rdAcc;
      if (rdAcc) begin
        haveData <= 1'b1;
        bypSel   <= bypHit;
        bypData  <= dataW;
      end
    end
  end

  always_comb begin
    dataR = '0;
    if (haveData) dataR = bypSel ? bypData : ramQ;
  end

endmodule

// File: tb/tb_memory_controller.sv
// Randomized self-checking bench for memory_controller against an array-based reference model.
// Uses a 14-bit address instance so several full clear sweeps fit the cycle budget.
`timescale 1ns/1ps

module tb_memory_controller;

  localparam int AW    = 14;
  localparam int DW    = 8;
  localparam int DEPTH = 2 ** AW;
  localparam logic [AW-1:0] TOP = AW'(DEPTH - 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          weW = 1'b0;
  logic [AW-1:0] addrW = '0;
  logic [DW-1:0] dataW = '0;
  logic          reR = 1'b0;
  logic [AW-1:0] addrR = '0;
  logic [DW-1:0] dataR;
  logic          validR;
  logic          ready;

  memory_controller #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .weW    (weW),
    .addrW  (addrW),
    .dataW  (dataW),
    .reR    (reR),
    .addrR  (addrR),
    .dataR  (dataR),
    .validR (validR),
    .ready  (ready)
  );

  always #5 clk = ~clk;

  // Reference model: contents after a completed sweep, plus the last read result.
  logic [DW-1:0] modelMem [DEPTH];
  logic [DW-1:0] expData;
  logic          expValid;
  int            compared   = 0;
  int            mismatched = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;
    expData  = '0;
    expValid = 1'b0;
  endtask

  task automatic driveIdle();
    weW = 1'b0; addrW = '0; dataW = '0; reR = 1'b0; addrR = '0;
  endtask

  // One cycle of traffic with ready=1; called and returns at a falling edge.
  task automatic step(input logic we, input logic [AW-1:0] aw, input logic [DW-1:0] dw,
                      input logic re, input logic [AW-1:0] ar, input string tag);
    weW = we; addrW = aw; dataW = dw; reR = re; addrR = ar;
    @(posedge clk);
    if (re) begin
      expData  = (we && aw == ar) ? dw : modelMem[ar];
      expValid = 1'b1;
    end else begin
      expValid = 1'b0;
    end
    if (we) modelMem[aw] = dw;
    @(negedge clk);
    checkVal({tag, ".valid"}, 32'(validR), 32'(expValid));
    checkVal({tag, ".data"},  32'(dataR),  32'(expData));
    driveIdle();
  endtask

  // Called just after reset release; ready must rise exactly DEPTH+1 edges later.
  task automatic sweep(input bit withReqs, input string tag);
    if (withReqs) begin
      weW = 1'b1; addrW = AW'(5); dataW = 8'h77; reR = 1'b1; addrR = AW'(5);
    end
    for (int i = 1; i <= DEPTH + 1; i++) begin
      @(posedge clk);
      #1;
      if (i % 4096 == 0 && i <= DEPTH) begin
        checkVal({tag, ".sweepValid"}, 32'(validR), 32'(0));
        checkVal({tag, ".sweepData"},  32'(dataR),  32'(0));
      end
      if (i == DEPTH)     checkVal({tag, ".readyLate"}, 32'(ready), 32'(0));
      if (i == DEPTH + 1) begin
        checkVal({tag, ".readyRise"}, 32'(ready), 32'(1));
        checkVal({tag, ".validIdle"}, 32'(validR), 32'(0));
      end
    end
    driveIdle();
    modelClear();
    @(negedge clk);
  endtask

  // 1 ns low pulse between edges; called at a falling edge.
  task automatic pulseReset(input string tag);
    rst_n = 1'b0;
    #1;
    checkVal({tag, ".rstData"},  32'(dataR),  32'(0));
    checkVal({tag, ".rstValid"}, 32'(validR), 32'(0));
    checkVal({tag, ".rstReady"}, 32'(ready),  32'(0));
    rst_n = 1'b1;
  endtask

  function automatic logic [AW-1:0] randAddr();
    if ($urandom_range(3, 0) != 0) return AW'(16'h0100 + 16'($urandom_range(15, 0)));
    return AW'($urandom_range(DEPTH - 1, 0));
  endfunction

  initial begin
    modelClear();
    driveIdle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("por.data",  32'(dataR),  32'(0));
    checkVal("por.valid", 32'(validR), 32'(0));
    checkVal("por.ready", 32'(ready),  32'(0));
    rst_n = 1'b1;

    // Abort a sweep part-way, with requests pending, and restart it.
    weW = 1'b1; addrW = AW'(5); dataW = 8'h77; reR = 1'b1; addrR = AW'(5);
    repeat (200) @(posedge clk);
    @(negedge clk);
    checkVal("midSweep.valid", 32'(validR), 32'(0));
    checkVal("midSweep.ready", 32'(ready),  32'(0));
    pulseReset("midSweep");
    sweep(1'b1, "sweep1");

    step(1'b0, '0, '0, 1'b1, AW'(16'h2000), "rdCleared");
    step(1'b1, AW'(16'h2000), 8'hA5, 1'b0, '0, "wrA5");
    step(1'b0, '0, '0, 1'b1, AW'(16'h2000), "rdA5");
    step(1'b0, '0, '0, 1'b1, AW'(16'h1FFF), "rdNeighbour");
    step(1'b1, AW'(16'h0040), 8'h3C, 1'b1, AW'(16'h0040), "rawSame");
    step(1'b1, AW'(16'h0041), 8'h11, 1'b1, AW'(16'h0040), "rawDiff");
    step(1'b0, '0, '0, 1'b0, '0, "holdIdle");
    step(1'b1, AW'(0), 8'h01, 1'b0, '0, "wrBottom");
    step(1'b1, TOP,    8'hFF, 1'b0, '0, "wrTop");
    step(1'b0, '0, '0, 1'b1, AW'(0), "rdBottom");
    step(1'b0, '0, '0, 1'b1, TOP,    "rdTop");
    step(1'b0, '0, '0, 1'b1, AW'(5), "rdIgnoredWr");

    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(1, 0)), randAddr(), 8'($urandom), 1'($urandom_range(1, 0)),
           randAddr(), "rand");
    end

    // Reset after data: contents must be re-zeroed by the new sweep.
    step(1'b1, AW'(16'h1234), 8'h55, 1'b1, AW'(16'h1234), "wr55");
    pulseReset("postData");
    sweep(1'b0, "sweep2");
    step(1'b0, '0, '0, 1'b1, AW'(16'h1234), "rdLost55");
    step(1'b0, '0, '0, 1'b1, AW'(16'h2000), "rdLostA5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
